// File: rtl/multicycle_cpu_core.sv
// Multi-cycle MIPS-32 subset core: one FSM state per cycle, a single shared
// instruction/data port with req/ready handshake, sticky halt and fault.
module multicycle_cpu_core #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           pc_out,
  output logic                  instr_retired,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_R, WB_MEM, BRANCH, JUMP, HALT, FAULT
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  stateT state, stateNext;

  logic [31:0] pc, pcNext;
  logic [31:0] ir, regA, regB, aluOut, mdr;
  logic [31:0] timeoutCnt;
  logic [31:0] regFile [32];

  logic                  memReqNext, memWeNext;
  logic [ADDR_WIDTH-1:0] memAddrNext;
  logic [31:0]           memWdataNext;

  logic        memDone, memWait, timeoutHit;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic signed [31:0] immExt;
  logic [31:0] effAddr;

  logic        rfWe;
  logic [4:0]  rfWaddr;
  logic [31:0] rfWdata;

  function automatic logic [31:0] aluR(input logic [5:0] f,
                                       input logic signed [31:0] a,
                                       input logic signed [31:0] b);
    case (f)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_SLT:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic legalFunct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign immExt  = {{16{ir[15]}}, ir[15:0]};
  assign effAddr = regA + immExt;

  assign memDone    = mem_req && mem_ready;
  assign memWait    = mem_req && !mem_ready;
  assign timeoutHit = TIMEOUT_EN && memWait && (timeoutCnt == TIMEOUT_LAST);

  assign pc_out = pc;

  // Next state, PC update, retire pulse and the registered memory-port values
  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    instr_retired = 1'b0;
    case (state)
      FETCH: begin
        if (timeoutHit) stateNext = FAULT;
        else if (memDone) begin
          stateNext = DECODE;
          pcNext    = pc + 32'd4;
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:     stateNext = legalFunct(funct) ? EXEC_R : HALT;
          OP_ADDI:      stateNext = EXEC_I;
          OP_LW, OP_SW: stateNext = MEM_ADDR;
          OP_BEQ, OP_BNE: stateNext = BRANCH;
          OP_J:         stateNext = JUMP;
          default:      stateNext = HALT;
        endcase
      end
      EXEC_R, EXEC_I: stateNext = WB_R;
      MEM_ADDR: begin
        if (effAddr[1:0] != 2'b00) stateNext = FAULT;
        else if (opcode == OP_LW)  stateNext = MEM_RD;
        else                       stateNext = MEM_WR;
      end
      MEM_RD: begin
        if (timeoutHit)   stateNext = FAULT;
        else if (memDone) stateNext = WB_MEM;
      end
      MEM_WR: begin
        if (timeoutHit) stateNext = FAULT;
        else if (memDone) begin
          stateNext     = FETCH;
          instr_retired = 1'b1;
        end
      end
      WB_R, WB_MEM: begin
        stateNext     = FETCH;
        instr_retired = 1'b1;
      end
      BRANCH: begin
        stateNext     = FETCH;
        instr_retired = 1'b1;
        // beq takes on equality, bne on inequality
        if ((opcode == OP_BEQ) == (regA == regB)) pcNext = aluOut;
      end
      JUMP: begin
        stateNext     = FETCH;
        instr_retired = 1'b1;
        pcNext        = {pc[31:28], ir[25:0], 2'b00};
      end
      HALT, FAULT: stateNext = state;
      default:     stateNext = FAULT;
    endcase

    memReqNext   = (stateNext == FETCH) || (stateNext == MEM_RD) || (stateNext == MEM_WR);
    memWeNext    = (stateNext == MEM_WR);
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;
    if (stateNext == FETCH)      memAddrNext = pcNext[ADDR_WIDTH-1:0];
    else if (state == MEM_ADDR)  memAddrNext = effAddr[ADDR_WIDTH-1:0];
    if (stateNext == MEM_WR)     memWdataNext = regB;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      timeoutCnt <= '0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      if (stateNext == HALT)  halted <= 1'b1;
      if (stateNext == FAULT) fault  <= 1'b1;
      timeoutCnt <= memWait ? timeoutCnt + 32'd1 : 32'd0;
    end
  end

  // Datapath holding registers carry no reset; they are always written before use
  always_ff @(posedge clk) begin
    if (state == FETCH && memDone)  ir  <= mem_rdata;
    if (state == MEM_RD && memDone) mdr <= mem_rdata;
    case (state)
      DECODE: begin
        regA   <= regFile[rs];
        regB   <= regFile[rt];
        aluOut <= pc + {immExt[29:0], 2'b00};
      end
      EXEC_R:           aluOut <= aluR(funct, regA, regB);
      EXEC_I, MEM_ADDR: aluOut <= effAddr;
      default: ;
    endcase
  end

  assign rfWe    = (state == WB_R) || (state == WB_MEM);
  assign rfWaddr = (state == WB_R && opcode == OP_RTYPE) ? rd : rt;
  assign rfWdata = (state == WB_MEM) ? mdr : aluOut;

  // Register 0 is never written, so it always reads back as zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (rfWe && rfWaddr != 5'd0) begin
      regFile[rfWaddr] <= rfWdata;
    end
  end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core: behavioural memory responder with
// fetch/write scoreboards, retire-timing log, timeout and misalignment faults.
module tb_multicycle_cpu_core;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, pc_out;
  logic        instr_retired, halted, fault;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dataReqs = 0;

  logic [31:0] mem [0:255];
  logic [31:0] expFetch[$];
  logic [31:0] expWrAddr[$];
  logic [31:0] expWrData[$];
  int          retireCyc[$];

  bit          noReady = 1'b0;
  logic [15:0] waitAddr = 16'hFFFF;
  int          waitN = 0;
  int          waitDone = 0;
  logic [15:0] holdAddr = '0;
  logic        holdWe = 1'b0;

  multicycle_cpu_core #(
    .RESET_PC      (32'h0000_0100),
    .ADDR_WIDTH    (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .pc_out       (pc_out),
    .instr_retired(instr_retired),
    .halted       (halted),
    .fault        (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    mem[a[9:2]] = d;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    expFetch.delete();
    expWrAddr.delete();
    expWrData.delete();
    retireCyc.delete();
    dataReqs = 0;
    waitDone = 0;
  endtask

  task automatic loadMain();
    clearMem();
    put(32'h100, 32'h20010005);  // addi $1,$0,5
    put(32'h104, 32'h00211020);  // add  $2,$1,$1
    put(32'h108, 32'hAC020040);  // sw   $2,0x40($0)
    put(32'h10C, 32'h10000002);  // beq  $0,$0,+2 -> 0x118
    put(32'h110, 32'hFC000000);
    put(32'h114, 32'hFC000000);
    put(32'h118, 32'h14000002);  // bne  $0,$0,+2 (not taken)
    put(32'h11C, 32'h8C030080);  // lw   $3,0x80($0)
    put(32'h120, 32'hAC030044);  // sw   $3,0x44($0)
    put(32'h124, 32'h00210020);  // add  $0,$1,$1
    put(32'h128, 32'hAC000048);  // sw   $0,0x48($0)
    put(32'h12C, 32'h00012022);  // sub  $4,$0,$1
    put(32'h130, 32'h0081282A);  // slt  $5,$4,$1
    put(32'h134, 32'h00233025);  // or   $6,$1,$3
    put(32'h138, 32'h00623824);  // and  $7,$3,$2
    put(32'h13C, 32'hAC04004C);
    put(32'h140, 32'hAC050050);
    put(32'h144, 32'hAC060054);
    put(32'h148, 32'hAC070058);
    put(32'h14C, 32'h08000058);  // j 0x160
    put(32'h150, 32'hFC000000);
    put(32'h160, 32'h2028FFFA);  // addi $8,$1,-6
    put(32'h164, 32'hAC08005C);
    put(32'h168, 32'hFC000000);  // illegal
    put(32'h080, 32'h12345678);
    expFetch = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h118, 32'h11C, 32'h120,
                 32'h124, 32'h128, 32'h12C, 32'h130, 32'h134, 32'h138, 32'h13C,
                 32'h140, 32'h144, 32'h148, 32'h14C, 32'h160, 32'h164, 32'h168};
    expWrAddr = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C};
    expWrData = '{32'd10, 32'h12345678, 32'h0, 32'hFFFFFFFB, 32'h1,
                  32'h1234567D, 32'h8, 32'hFFFFFFFF};
  endtask

  // Memory responder: decides mem_ready for the coming edge just after each edge
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (rst && mem_req && !noReady) begin
        if (mem_addr == waitAddr && waitDone < waitN) begin
          if (waitDone == 0) begin
            holdAddr = mem_addr;
            holdWe   = mem_we;
          end else begin
            chk("wait_addr_hold", {16'h0, mem_addr}, {16'h0, holdAddr});
            chk("wait_we_hold", {31'h0, mem_we}, {31'h0, holdWe});
          end
          mem_rdata = 32'hDEADBEEF;
          waitDone++;
        end else begin
          if (waitDone > 0) chk("ready_we_hold", {31'h0, mem_we}, {31'h0, holdWe});
          waitDone  = 0;
          mem_ready = 1'b1;
          if (mem_addr < 16'h100) dataReqs++;
          if (mem_we) begin
            if (expWrAddr.size() == 0) chk("write_unexpected", {16'h0, mem_addr}, 32'hFFFFFFFF);
            else begin
              chk("write_addr", {16'h0, mem_addr}, expWrAddr.pop_front());
              chk("write_data", mem_wdata, expWrData.pop_front());
            end
            mem[mem_addr[9:2]] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr[9:2]];
            if (mem_addr >= 16'h100) begin
              if (expFetch.size() == 0) chk("fetch_unexpected", {16'h0, mem_addr}, 32'hFFFFFFFF);
              else chk("fetch_addr", {16'h0, mem_addr}, expFetch.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) cyc = 0;
      else cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst && instr_retired) retireCyc.push_back(cyc);
    end
  end

  initial begin
    int expRet[6];
    expRet = '{4, 8, 12, 15, 18, 26};
    rst = 1'b0;
    waitAddr = 16'h0080;
    waitN = 3;
    loadMain();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pc", pc_out, 32'h100);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_retired", {31'h0, instr_retired}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);

    // Main program: ALU, stores, branches, wait-stated load, jump, illegal
    rst = 1'b1;
    @(negedge clk);
    chk("first_req", {31'h0, mem_req}, 32'h1);
    chk("first_addr", {16'h0, mem_addr}, 32'h100);
    chk("first_we", {31'h0, mem_we}, 32'h0);
    for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
    chk("halted", {31'h0, halted}, 32'h1);
    chk("halt_fault", {31'h0, fault}, 32'h0);
    chk("halt_pc", pc_out, 32'h16C);
    chk("retire_total", 32'(retireCyc.size()), 32'd20);
    for (int i = 0; i < 6; i++)
      chk($sformatf("retire_cycle_%0d", i),
          (i < retireCyc.size()) ? 32'(retireCyc[i]) : 32'hFFFFFFFF, 32'(expRet[i]));
    chk("fetch_left", 32'(expFetch.size()), 32'd0);
    chk("writes_left", 32'(expWrAddr.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("halt_req", {31'h0, mem_req}, 32'h0);
    chk("halt_pc_frozen", pc_out, 32'h16C);

    // Reset mid-transaction, then memory timeout in FETCH
    rst = 1'b0;
    clearMem();
    noReady = 1'b1;
    @(negedge clk);
    chk("rst2_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst2_halted", {31'h0, halted}, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("pending_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b0;
    #1;
    chk("async_rst_req", {31'h0, mem_req}, 32'h0);
    chk("async_rst_pc", pc_out, 32'h100);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("timeout_pre_fault", {31'h0, fault}, 32'h0);
    chk("timeout_pre_req", {31'h0, mem_req}, 32'h1);
    chk("timeout_addr_held", {16'h0, mem_addr}, 32'h100);
    @(negedge clk);
    chk("timeout_fault", {31'h0, fault}, 32'h1);
    chk("timeout_req", {31'h0, mem_req}, 32'h0);
    chk("timeout_pc", pc_out, 32'h100);
    chk("timeout_halted", {31'h0, halted}, 32'h0);

    // Misaligned load faults without a data request
    rst = 1'b0;
    clearMem();
    noReady = 1'b0;
    waitN = 0;
    put(32'h100, 32'h20010003);  // addi $1,$0,3
    put(32'h104, 32'h8C220000);  // lw   $2,0($1)
    put(32'h108, 32'hAC020040);
    expFetch = '{32'h100, 32'h104};
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50 && !fault; i++) @(negedge clk);
    chk("misalign_fault", {31'h0, fault}, 32'h1);
    chk("misalign_halted", {31'h0, halted}, 32'h0);
    chk("misalign_pc", pc_out, 32'h108);
    chk("misalign_data_reqs", 32'(dataReqs), 32'd0);
    chk("misalign_fetch_left", 32'(expFetch.size()), 32'd0);
    repeat (2) @(negedge clk);
    chk("misalign_req", {31'h0, mem_req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
